imem_prog: RTL and testbench

Parametrised, loadable instruction memory for the RV32 core fetch stage.
- Replaces a fixed combinational ROM with a synchronous-read RAM.
- Has a valid/ready fetch port with alignment and range fault reporting.
- After reset, a self-initialisation pass fills every word with NOP.
- A program port, usable only while fetch is quiesced, loads the program image.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_ram.sv | 32 +++
 rtl/imem_prog.sv | 113 +++++++++++
 tb/tb_imem_prog.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and enums for the loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    PROG = 2'd2
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM; read register clears on reset or on a faulting fetch.
module imem_ram #(
  parameter  int unsigned N     = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_rd_clr,
  input  logic [AW-1:0] i_addr,
  input  logic [N-1:0]  i_wdata,
  output logic [N-1:0]  o_rdata
);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read register doubles as the response data register, so it only moves on a fetch.
  always_ff @(posedge clk) begin
    if (i_reset || i_rd_clr) r_rdata <= '0;
    else if (i_re)           r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory: NOP self-init after reset, program port, valid/ready fetch.
module imem_prog
  import imem_pkg::*;
#(
  parameter  int unsigned N     = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_data,
  output logic [1:0]    resp_fault,
  input  logic          prog_en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [N-1:0]  prog_wdata,
  output logic          busy
);

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_init_cnt;
  logic          r_resp_valid;
  fault_e        r_resp_fault;

  logic          w_hs;
  fault_e        w_fault;
  logic          w_we;
  logic          w_re;
  logic          w_rd_clr;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  w_wdata;
  logic [N-1:0]  w_rdata;

  assign req_ready = (r_state == RUN) && !prog_en && (!r_resp_valid || resp_ready);
  assign w_hs      = req_valid && req_ready;

  // Misalignment outranks out-of-range.
  always_comb begin
    w_fault = FAULT_NONE;
    if (req_addr[1:0] != 2'b00)           w_fault = FAULT_MISALIGN;
    else if ((req_addr >> (AW + 2)) != '0) w_fault = FAULT_RANGE;
  end

  assign w_re     = w_hs && (w_fault == FAULT_NONE);
  assign w_rd_clr = w_hs && (w_fault != FAULT_NONE);

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_addr      = req_addr[AW+1:2];
    w_wdata     = prog_wdata;
    case (r_state)
      INIT: begin
        w_we    = 1'b1;
        w_addr  = r_init_cnt;
        w_wdata = N'(NOP_INSN);
        if (r_init_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        if (prog_en && !r_resp_valid) w_state_nxt = PROG;
      end
      PROG: begin
        w_addr = prog_addr;
        if (!prog_en) w_state_nxt = RUN;
        else          w_we        = prog_we;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_init_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= FAULT_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + AW'(1);
      if (w_hs) begin
        r_resp_valid <= 1'b1;
        r_resp_fault <= w_fault;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  imem_ram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .i_reset  (reset),
    .i_we     (w_we),
    .i_re     (w_re),
    .i_rd_clr (w_rd_clr),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_data  = w_rdata;
  assign busy       = (r_state != RUN);

endmodule

// File: tb/tb_imem_prog.sv
// Scoreboard bench for imem_prog: expectations queued at each handshake, checked when taken.
module tb_imem_prog;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  logic        prog_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_wdata = '0;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] model [64];
  logic [33:0] q [$];
  logic [33:0] e;

  imem_prog dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .prog_en    (prog_en),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] expect_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return {2'd1, 32'd0};
    if (a[31:8] != 24'd0) return {2'd2, 32'd0};
    return {2'd0, model[a[7:2]]};
  endfunction

  // Response monitor: valid must track outstanding expectations one cycle after handshake.
  always @(negedge clk) begin
    if (!reset) begin
      chk("resp_valid", 64'(resp_valid), 64'(q.size() != 0));
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) chk("spurious_resp", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          chk("resp_data", 64'(resp_data), 64'(e[31:0]));
          chk("resp_fault", 64'(resp_fault), 64'(e[33:32]));
        end
      end
      if (req_valid && req_ready) q.push_back(expect_of(req_addr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; prog_en = 1'b0; prog_we = 1'b0; resp_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 64; i++) model[i] = NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_fault", 64'(resp_fault), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_busy", 64'(busy), 64'(1));
      chk("init_req_ready", 64'(req_ready), 64'(0));
      if (i == 63) req_valid = 1'b0;
    end
    @(negedge clk);
    chk("run_busy", 64'(busy), 64'(0));
    chk("run_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("hs_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic prog_enter();
    prog_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("prog_busy", 64'(busy), 64'(1));
  endtask

  task automatic prog_write(input logic [5:0] idx, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = idx; prog_wdata = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    model[idx] = d;
  endtask

  initial begin
    do_reset();

    fetch(32'h00); fetch(32'h04); fetch(32'hFC);

    prog_enter();
    prog_write(6'd2, 32'h3004_5073);
    prog_write(6'd63, 32'h00c0_006f);
    // Write strobe in the exit cycle must be dropped.
    prog_en = 1'b0; prog_we = 1'b1; prog_addr = 6'd2; prog_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    prog_we = 1'b0;
    fetch(32'h08); fetch(32'hFC);

    fetch(32'h06); fetch(32'h100); fetch(32'h102);

    // Back-pressure: first request taken, the rest stall until resp_ready returns.
    req_valid = 1'b1; req_addr = 32'h08;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_addr = 32'hFC;
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      chk("stall_hold_data", 64'(resp_data), 64'(32'h3004_5073));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1; req_addr = 32'h04;
    @(posedge clk); #1; req_addr = 32'h06;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // prog_en while a response is pending must wait for the drain.
    resp_ready = 1'b0;
    fetch(32'h0C);
    prog_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("drain_req_ready", 64'(req_ready), 64'(0));
      chk("drain_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_still_run", 64'(busy), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_in_prog", 64'(busy), 64'(1));
    chk("drain_prog_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    prog_write(6'd5, 32'hDEAD_BEEF);

    do_reset();
    fetch(32'h14);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
